systolic_sched: RTL and testbench
=================================

Name: systolic_sched

Overview:
- Sequencing controller for the systolic PE-array plus accumulation datapath.
- Accepts one layer job: layer id, number of 4-channel input groups, number of 8-batch output groups.
- Per output group: pulses the accumulator start, then for each input group loads 8 weight batches and feeds one 4-channel feature-map beat. It then waits for all 16 PE outputs before advancing.
- Sits between the weight/feature-map buffer readers and the systolic accumulation block.

Parameters:
- CG_W, 8, width of the input-channel-group count.
- OG_W, 8, width of the output-group count.
- TIMEOUT_CYC, 1024, watchdog limit in the WAIT_OUT state; used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  job request.
- cfg_ready  out  1  scheduler idle and able to accept a job.
- cfg_layer  in  3  layer id for the job.
- cfg_n_cin  in  CG_W  number of input-channel groups.
- cfg_n_cout  in  OG_W  number of output groups.
- w_valid  in  1  weight buffer holds 8 batches for the current group.
- w_rd  out  1  weight buffer pop.
- fm_valid  in  1  feature-map buffer holds a 4-channel beat.
- fm_rd  out  1  feature-map buffer pop.
- acc_start  out  1  start pulse to the accumulator.
- acc_layer  out  3  layer id to the accumulator.
- en_w  out  8  weight enables to the array.
- en_fm  out  4  feature-map enables to the array.
- en_out  in  16  output-valid flags from the accumulator.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse when the job completes.
- err  out  1  sticky watchdog error.

Behaviour:
- States: IDLE, START, LOAD_W, FEED, WAIT_OUT.
- IDLE
  - cfg_ready=1.
  - On cfg_valid: latch cfg_layer into acc_layer, latch n_cin and n_cout (a value of 0 is stored as 1), clear cin_cnt and cout_cnt, go to START.
- START
  - acc_start=1 for exactly this one cycle; go to LOAD_W.
- LOAD_W
  - en_w=8'hFF and w_rd=1 combinationally in the same cycle w_valid=1; then go to FEED.
  - While w_valid=0: stall, en_w=0.
- FEED
  - en_fm=4'hF and fm_rd=1 in the same cycle fm_valid=1.
  - If cin_cnt==n_cin-1: clear cin_cnt, go to WAIT_OUT.
  - Otherwise: cin_cnt++, go to LOAD_W.
  - While fm_valid=0: stall.
- WAIT_OUT
  - Wait until en_out==16'hFFFF; partial en_out patterns are ignored.
  - If cout_cnt==n_cout-1: done=1 (registered, one cycle), go to IDLE.
  - Otherwise: cout_cnt++, go to START.
- Output rules
  - en_w, en_fm, w_rd and fm_rd are never asserted outside LOAD_W and FEED respectively.
  - acc_start, done, busy and acc_layer are registered.
  - busy=1 in every state except IDLE.
- Job timing: minimum cycles per job = 1 (accept) + n_cout*(1 + 2*n_cin + 1), with all valids high and en_out returning immediately.
- cfg_valid while busy: ignored. cfg_ready=0, so no handshake occurs.
- Reset values: all outputs 0 except cfg_ready=1; state=IDLE; counters 0.
- Reset is asynchronous and takes effect mid-job. No buffer pops are issued after reset asserts; in-flight buffer contents are the upstream owner's responsibility.
- The counter compare uses the stored minus-one values so that n=1 exercises a single iteration.

Optional Feature:
- Macro: SYSTOLIC_SCHED_TIMEOUT_EN.
- Defined
  - A watchdog counter runs in WAIT_OUT.
  - When it reaches TIMEOUT_CYC without en_out==16'hFFFF: set err (sticky until rst), pulse done, return to IDLE.
  - The counter clears on every WAIT_OUT entry.
- Undefined
  - No counter is built, err is tied to 0, and WAIT_OUT waits indefinitely.

Decomposition:
- Shared package holds:
  - the state encoding (3-bit localparams);
  - EN_W_ALL=8'hFF;
  - EN_FM_ALL=4'hF;
  - EN_OUT_ALL=16'hFFFF.
- One natural sub-module, systolic_sched_cnt: a loadable down/up counter with a last flag, instanced for cin and cout. The watchdog reuses it when SYSTOLIC_SCHED_TIMEOUT_EN is defined.

Test Plan:
- Single-group job (layer=3, n_cin=1, n_cout=1, valids high, en_out=FFFF one cycle after FEED).
  - acc_start pulses once, then one en_w=FF beat, then one en_fm=F beat.
  - done pulses; acc_layer=3; busy high for exactly the job duration.
- Multi-group job (n_cin=3, n_cout=2).
  - Exactly 6 w_rd pulses, 6 fm_rd pulses, 2 acc_start pulses and 1 done.
  - en_w and en_fm alternate; no en_w occurs during WAIT_OUT.
- Backpressure: hold w_valid=0 for 5 cycles, then fm_valid=0 for 4 cycles.
  - No en_w/en_fm while the valid is low; the beat is issued in the cycle the valid rises.
  - Job cycle count grows by exactly 9.
- Partial output: en_out=16'h7FFF for 10 cycles, then FFFF.
  - No advance during the 10 cycles; the group advances on FFFF.
  - cfg_valid pulsed during the job is ignored (cfg_ready=0).
- Zero and reset: cfg_n_cin=0, cfg_n_cout=0 behaves exactly like 1/1.
  - Asserting rst in FEED forces all outputs to 0 and cfg_ready=1 immediately.
  - A new job after reset runs cleanly.
- Watchdog (macro defined, TIMEOUT_CYC=16, en_out stuck at 0).
  - err=1 and done pulses at the 16th WAIT_OUT cycle; state returns to IDLE.
  - With the macro undefined, the scheduler stays busy and err stays 0.

Source files
------------

// File: rtl/systolic_sched_pkg.sv
// rtl/systolic_sched_pkg.sv - state encoding and array enable constants for the systolic scheduler
package systolic_sched_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_START    = 3'd1;
    localparam logic [2:0] ST_LOAD_W   = 3'd2;
    localparam logic [2:0] ST_FEED     = 3'd3;
    localparam logic [2:0] ST_WAIT_OUT = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_START    = ST_START,
        S_LOAD_W   = ST_LOAD_W,
        S_FEED     = ST_FEED,
        S_WAIT_OUT = ST_WAIT_OUT
    } state_t;

    localparam logic [7:0]  EN_W_ALL   = 8'hFF;
    localparam logic [3:0]  EN_FM_ALL  = 4'hF;
    localparam logic [15:0] EN_OUT_ALL = 16'hFFFF;

endpackage

// File: rtl/systolic_sched_if.sv
// rtl/systolic_sched_if.sv - job, buffer and array handshake bundle for the systolic scheduler
// master: scheduler side (drives cfg_ready, buffer pops, array enables, acc_*, busy/done/err)
// slave : environment side (drives cfg_*, w_valid, fm_valid, en_out)
interface systolic_sched_if #(
    parameter int CG_W = 8,
    parameter int OG_W = 8
);
    logic            cfg_valid;
    logic            cfg_ready;
    logic [2:0]      cfg_layer;
    logic [CG_W-1:0] cfg_n_cin;
    logic [OG_W-1:0] cfg_n_cout;
    logic            w_valid;
    logic            w_rd;
    logic            fm_valid;
    logic            fm_rd;
    logic            acc_start;
    logic [2:0]      acc_layer;
    logic [7:0]      en_w;
    logic [3:0]      en_fm;
    logic [15:0]     en_out;
    logic            busy;
    logic            done;
    logic            err;

    modport master (
        input  cfg_valid, cfg_layer, cfg_n_cin, cfg_n_cout, w_valid, fm_valid, en_out,
        output cfg_ready, w_rd, fm_rd, acc_start, acc_layer, en_w, en_fm, busy, done, err
    );

    modport slave (
        output cfg_valid, cfg_layer, cfg_n_cin, cfg_n_cout, w_valid, fm_valid, en_out,
        input  cfg_ready, w_rd, fm_rd, acc_start, acc_layer, en_w, en_fm, busy, done, err
    );
endinterface

// File: rtl/systolic_sched_cnt.sv
// rtl/systolic_sched_cnt.sv - loadable iteration counter with terminal-count flag
// clk, rst (async, active-low); load: capture lim and restart at 0; clr: restart at 0;
// inc: advance by one; last: count equals the captured limit
module systolic_sched_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] lim,
    input  logic         clr,
    input  logic         inc,
    output logic         last
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] lim_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            lim_q <= '0;
        end else if (load) begin
            cnt_q <= '0;
            lim_q <= lim;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign last = (cnt_q == lim_q);
endmodule

// File: rtl/systolic_sched.sv
// rtl/systolic_sched.sv - layer job sequencer for the systolic PE array and accumulator
// clk, rst (async, active-low); bus: systolic_sched_if.master carrying the job request,
// weight/feature-map buffer pops, array enables, accumulator start/layer and busy/done/err.
// Optional: SYSTOLIC_SCHED_TIMEOUT_EN builds a WAIT_OUT watchdog of TIMEOUT_CYC cycles.
module systolic_sched
    import systolic_sched_pkg::*;
#(
    parameter int CG_W        = 8,
    parameter int OG_W        = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    systolic_sched_if.master  bus
);
    state_t          state;
    logic            acc_start_q;
    logic            done_q;
    logic            busy_q;
    logic [2:0]      layer_q;

    logic            accept;
    logic            w_fire;
    logic            fm_fire;
    logic            out_all;
    logic            cin_last;
    logic            cout_last;
    logic [CG_W-1:0] cin_lim;
    logic [OG_W-1:0] cout_lim;

    assign accept  = (state == S_IDLE) && bus.cfg_valid;
    assign w_fire  = (state == S_LOAD_W) && bus.w_valid;
    assign fm_fire = (state == S_FEED) && bus.fm_valid;
    assign out_all = (state == S_WAIT_OUT) && (bus.en_out == EN_OUT_ALL);

    // A zero count runs as a single iteration; the counters compare against n-1.
    assign cin_lim  = (bus.cfg_n_cin  == '0) ? '0 : bus.cfg_n_cin  - 1'b1;
    assign cout_lim = (bus.cfg_n_cout == '0) ? '0 : bus.cfg_n_cout - 1'b1;

    systolic_sched_cnt #(.W(CG_W)) u_cin (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .lim  (cin_lim),
        .clr  (fm_fire && cin_last),
        .inc  (fm_fire && !cin_last),
        .last (cin_last)
    );

    systolic_sched_cnt #(.W(OG_W)) u_cout (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .lim  (cout_lim),
        .clr  (1'b0),
        .inc  (out_all && !cout_last),
        .last (cout_last)
    );

`ifdef SYSTOLIC_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;
    logic wd_last;
    logic err_q;

    // Reloaded on every WAIT_OUT entry, so each output group gets a fresh budget.
    systolic_sched_cnt #(.W(WD_W)) u_wd (
        .clk  (clk),
        .rst  (rst),
        .load (fm_fire && cin_last),
        .lim  (WD_W'(TIMEOUT_CYC - 1)),
        .clr  (1'b0),
        .inc  (state == S_WAIT_OUT),
        .last (wd_last)
    );

    assign bus.err = err_q;
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            acc_start_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            layer_q     <= 3'd0;
`ifdef SYSTOLIC_SCHED_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
        end else begin
            acc_start_q <= 1'b0;
            done_q      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.cfg_valid) begin
                        layer_q     <= bus.cfg_layer;
                        acc_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state       <= S_START;
                    end
                end
                S_START: begin
                    state <= S_LOAD_W;
                end
                S_LOAD_W: begin
                    if (bus.w_valid) state <= S_FEED;
                end
                S_FEED: begin
                    if (bus.fm_valid) state <= cin_last ? S_WAIT_OUT : S_LOAD_W;
                end
                S_WAIT_OUT: begin
                    if (out_all) begin
                        if (cout_last) begin
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                            state  <= S_IDLE;
                        end else begin
                            acc_start_q <= 1'b1;
                            state       <= S_START;
                        end
                    end
`ifdef SYSTOLIC_SCHED_TIMEOUT_EN
                    else if (wd_last) begin
                        err_q  <= 1'b1;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end
`endif
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cfg_ready = (state == S_IDLE);
    assign bus.w_rd      = w_fire;
    assign bus.en_w      = w_fire ? EN_W_ALL : 8'h00;
    assign bus.fm_rd     = fm_fire;
    assign bus.en_fm     = fm_fire ? EN_FM_ALL : 4'h0;
    assign bus.acc_start = acc_start_q;
    assign bus.acc_layer = layer_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_systolic_sched.sv
// tb/tb_systolic_sched.sv - scoreboard bench for the systolic scheduler
module tb_systolic_sched;

    localparam int EV_START = 1;
    localparam int EV_W     = 2;
    localparam int EV_F     = 3;
    localparam int EV_DONE  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    systolic_sched_if #(.CG_W(8), .OG_W(8)) bus ();

    systolic_sched #(.CG_W(8), .OG_W(8), .TIMEOUT_CYC(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int busy_total = 0;
    bit seen_done = 1'b0;
    int exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic observe(input int code);
        int e;
        if (exp_q.size() == 0) begin
            chk("evt_unexpected", code, 0);
        end else begin
            e = exp_q.pop_front();
            chk("evt_order", code, e);
        end
    endtask

    task automatic sample();
        if (bus.busy) busy_total++;
        chk("ready_vs_busy", bus.cfg_ready, !bus.busy);
        chk("en_w_with_rd", bus.en_w, bus.w_rd ? 8'hFF : 8'h00);
        chk("en_fm_with_rd", bus.en_fm, bus.fm_rd ? 4'hF : 4'h0);
        chk("w_rd_needs_valid", bus.w_rd & ~bus.w_valid, 0);
        chk("fm_rd_needs_valid", bus.fm_rd & ~bus.fm_valid, 0);
        if (bus.acc_start) observe(EV_START | (int'(bus.acc_layer) << 4));
        if (bus.w_rd) observe(EV_W);
        if (bus.fm_rd) observe(EV_F);
        if (bus.done) begin
            seen_done = 1'b1;
            observe(EV_DONE | (int'(bus.acc_layer) << 4));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rst) sample();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk(tag, {bus.acc_start, bus.done, bus.busy, bus.w_rd, bus.fm_rd, bus.err,
                  bus.en_w, bus.en_fm, bus.acc_layer, ~bus.cfg_ready}, 0);
    endtask

    task automatic start_job(input logic [2:0] layer, input logic [7:0] ncin,
                             input logic [7:0] ncout, input bit push_done, output int base);
        int ec;
        int eo;
        ec = (ncin == 0) ? 1 : int'(ncin);
        eo = (ncout == 0) ? 1 : int'(ncout);
        for (int o = 0; o < eo; o++) begin
            exp_q.push_back(EV_START | (int'(layer) << 4));
            for (int i = 0; i < ec; i++) begin
                exp_q.push_back(EV_W);
                exp_q.push_back(EV_F);
            end
        end
        if (push_done) exp_q.push_back(EV_DONE | (int'(layer) << 4));
        chk("cfg_ready_idle", bus.cfg_ready, 1);
        bus.cfg_layer  = layer;
        bus.cfg_n_cin  = ncin;
        bus.cfg_n_cout = ncout;
        bus.cfg_valid  = 1'b1;
        seen_done = 1'b0;
        base = busy_total;
        tick();
        bus.cfg_valid = 1'b0;
    endtask

    task automatic finish_job(input int base, input int exp_busy, input int limit);
        for (int i = 0; i < limit && !seen_done; i++) tick();
        chk("done_seen", seen_done, 1);
        chk("busy_cycles", busy_total - base, exp_busy);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int base;
        bus.cfg_valid  = 1'b0;
        bus.cfg_layer  = 3'd0;
        bus.cfg_n_cin  = 8'd0;
        bus.cfg_n_cout = 8'd0;
        bus.w_valid    = 1'b1;
        bus.fm_valid   = 1'b1;
        bus.en_out     = 16'hFFFF;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset_state");
        rst = 1'b1;
        tick();
        tick();

        // single group
        start_job(3'd3, 8'd1, 8'd1, 1'b1, base);
        finish_job(base, 4, 20);
        chk("acc_layer_hold", bus.acc_layer, 3);

        // three input groups, two output groups
        start_job(3'd1, 8'd3, 8'd2, 1'b1, base);
        finish_job(base, 16, 60);

        // buffer backpressure: 5 cycles without weights, then 4 without a feature beat
        bus.w_valid  = 1'b0;
        bus.fm_valid = 1'b0;
        start_job(3'd2, 8'd1, 8'd1, 1'b1, base);
        repeat (6) tick();
        bus.w_valid = 1'b1;
        repeat (5) tick();
        bus.fm_valid = 1'b1;
        finish_job(base, 13, 30);

        // partial outputs for 10 cycles, with an ignored request mid-job
        bus.en_out = 16'h7FFF;
        start_job(3'd5, 8'd1, 8'd1, 1'b1, base);
        for (int k = 0; k < 13; k++) begin
            tick();
            if (k == 3) begin
                chk("cfg_ready_while_busy", bus.cfg_ready, 0);
                bus.cfg_valid = 1'b1;
                bus.cfg_layer = 3'd7;
            end else begin
                bus.cfg_valid = 1'b0;
            end
        end
        bus.en_out = 16'hFFFF;
        finish_job(base, 14, 30);

        // asynchronous reset while in FEED
        bus.fm_valid = 1'b0;
        start_job(3'd2, 8'd1, 8'd1, 1'b1, base);
        tick();
        tick();
        #2 rst = 1'b0;
        #1 chk_reset_outputs("reset_in_feed");
        bus.fm_valid = 1'b1;
        #1 chk_reset_outputs("reset_no_pop");
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        tick();

        // zero counts run as 1/1
        start_job(3'd6, 8'd0, 8'd0, 1'b1, base);
        finish_job(base, 4, 20);

        // outputs never complete
        bus.en_out = 16'h0000;
`ifdef SYSTOLIC_SCHED_TIMEOUT_EN
        start_job(3'd4, 8'd1, 8'd1, 1'b1, base);
        finish_job(base, 19, 60);
        chk("wd_err", bus.err, 1);
        chk("wd_done_pulse", bus.done, 0);
        chk("wd_idle", bus.cfg_ready, 1);
`else
        start_job(3'd4, 8'd1, 8'd1, 1'b0, base);
        repeat (40) tick();
        chk("stuck_busy", bus.busy, 1);
        chk("no_err", bus.err, 0);
        chk("stuck_queue", exp_q.size(), 0);
`endif
        rst = 1'b0;
        #1 chk_reset_outputs("reset_clear");
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
